fetch_ctrl: RTL and testbench

- Sequencing controller for the fetch-stage program counter.
- Each cycle it resolves stall, redirect, exception, return-from-exception and halt requests from later pipeline stages into the PC select/stall controls.
- Owns the exception PC (EPC) register and the halt-drain state machine.
- Sits between decode/execute/memory hazard logic and the PC register block; also drives the fetch/decode flush.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/drain_counter.sv | 39 +++
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC sequencing controller:
// state encodings, PC-select class constants and default parameters.
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_HANDLER = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_HALTED  = 3'd3
   } fetch_state_e;

   // PC-select classes; exactly one is presented to the PC block per cycle.
   typedef enum logic [2:0] {
      CLS_INC  = 3'd0,
      CLS_BR   = 3'd1,
      CLS_JR   = 3'd2,
      CLS_EXC  = 3'd3,
      CLS_HOLD = 3'd4
   } pc_class_e;

   localparam int          DRAIN_CYCLES_DEF = 3;
   localparam int          DRAIN_CNT_W      = 8;
   localparam logic [15:0] EXC_VECTOR       = 16'h0002;

endpackage

// File: rtl/drain_counter.sv
// Loadable down-counter used to time the halt drain; holds at zero and
// while frozen.
module drain_counter
   import fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [DRAIN_CNT_W-1:0] load_val,
   input  logic                   dec,
   input  logic                   freeze,
   output logic [DRAIN_CNT_W-1:0] cnt,
   output logic                   zero
);

   logic [DRAIN_CNT_W-1:0] cnt_q;
   logic [DRAIN_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && !freeze && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencing controller: resolves stall/redirect/exception/
// halt requests into PC select controls, owns EPC and the halt-drain FSM.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stall,
   input  logic        dmem_stall,
   input  logic        hazard_stall,
   input  logic        br_taken,
   input  logic        jr_taken,
   input  logic        siic_dec,
   input  logic        rti_dec,
   input  logic        halt_dec,
   input  logic [15:0] ex_pc,
   output logic        pc_sel,
   output logic        reg_jmp,
   output logic        hold,
   output logic        siic,
   output logic        pc_stall,
   output logic        epc_sel,
   output logic [15:0] epc,
   output logic        flush,
   output logic        halted,
   output logic [2:0]  state
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_e state_q, state_d;
   logic [15:0]  epc_q, epc_d;
   logic         saved_hdl_q, saved_hdl_d;

   pc_class_e cls;
   logic      stall_c, epc_sel_c, flush_c, halted_c;
   logic      cnt_load, cnt_dec, cnt_zero;
   logic [DRAIN_CNT_W-1:0] cnt_val;

   drain_counter u_drain_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (DRAIN_LOAD),
      .dec      (cnt_dec),
      .freeze   (dmem_stall),
      .cnt      (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      epc_d       = epc_q;
      saved_hdl_d = saved_hdl_q;
      cls         = CLS_INC;
      stall_c     = 1'b0;
      epc_sel_c   = 1'b0;
      flush_c     = 1'b0;
      halted_c    = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state_q)
         ST_RUN, ST_HANDLER: begin
            if (dmem_stall) begin
               cls = CLS_HOLD;
            end else if (br_taken) begin
               cls     = CLS_BR;
               flush_c = 1'b1;
            end else if (jr_taken) begin
               cls     = CLS_JR;
               flush_c = 1'b1;
            end else if (siic_dec && (state_q == ST_RUN)) begin
               cls     = CLS_EXC;
               flush_c = 1'b1;
               epc_d   = ex_pc;
               state_d = ST_HANDLER;
            end else if (rti_dec && (state_q == ST_HANDLER)) begin
               cls       = CLS_JR;
               epc_sel_c = 1'b1;
               flush_c   = 1'b1;
               state_d   = ST_RUN;
            end else if (halt_dec || siic_dec) begin
               // A SIIC reaching here is nested inside the handler: halt instead.
               cls         = CLS_HOLD;
               flush_c     = 1'b1;
               cnt_load    = 1'b1;
               saved_hdl_d = (state_q == ST_HANDLER);
               state_d     = ST_DRAIN;
            end else if (if_stall || hazard_stall) begin
               stall_c = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (dmem_stall) begin
               cls = CLS_HOLD;
            end else if (br_taken || jr_taken) begin
               // An older instruction redirected: the halt was on a wrong path.
               cls     = br_taken ? CLS_BR : CLS_JR;
               flush_c = 1'b1;
               state_d = saved_hdl_q ? ST_HANDLER : ST_RUN;
            end else begin
               cls = CLS_HOLD;
               if (cnt_zero) begin
                  state_d = ST_HALTED;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         ST_HALTED: begin
            cls      = CLS_HOLD;
            halted_c = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         epc_q       <= 16'h0000;
         saved_hdl_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         epc_q       <= epc_d;
         saved_hdl_q <= saved_hdl_d;
      end
   end

   // Outputs are forced quiet for as long as reset is held.
   assign pc_sel   = !rst && (cls == CLS_BR);
   assign reg_jmp  = !rst && (cls == CLS_JR);
   assign hold     = !rst && (cls == CLS_HOLD);
   assign siic     = !rst && (cls == CLS_EXC);
   assign pc_stall = !rst && stall_c;
   assign epc_sel  = !rst && epc_sel_c;
   assign flush    = !rst && flush_c;
   assign halted   = !rst && halted_c;
   assign epc      = epc_q;
   assign state    = state_q;

   logic unused_cnt;
   assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector scoreboard bench for fetch_ctrl.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_stall, dmem_stall, hazard_stall, br_taken, jr_taken;
   logic        siic_dec, rti_dec, halt_dec;
   logic [15:0] ex_pc;
   logic        pc_sel, reg_jmp, hold, siic, pc_stall, epc_sel, flush, halted;
   logic [15:0] epc;
   logic [2:0]  state;

   fetch_ctrl #(.DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .if_stall(if_stall), .dmem_stall(dmem_stall),
      .hazard_stall(hazard_stall), .br_taken(br_taken), .jr_taken(jr_taken),
      .siic_dec(siic_dec), .rti_dec(rti_dec), .halt_dec(halt_dec), .ex_pc(ex_pc),
      .pc_sel(pc_sel), .reg_jmp(reg_jmp), .hold(hold), .siic(siic),
      .pc_stall(pc_stall), .epc_sel(epc_sel), .epc(epc), .flush(flush),
      .halted(halted), .state(state)
   );

   always #5 clk = ~clk;

   // Request bits: {if_stall, dmem_stall, hazard_stall, br, jr, siic, rti, halt}
   localparam logic [7:0] R_NONE = 8'h00, R_HALT = 8'h01, R_RTI = 8'h02, R_SIIC = 8'h04;
   localparam logic [7:0] R_JR = 8'h08, R_BR = 8'h10, R_HAZ = 8'h20, R_DMEM = 8'h40;

   // Control bits: {pc_sel, reg_jmp, hold, siic, pc_stall, epc_sel, flush, halted}
   localparam logic [7:0] C_INC = 8'b0000_0000, C_BR = 8'b1000_0010, C_JR = 8'b0100_0010;
   localparam logic [7:0] C_HOLD = 8'b0010_0000, C_HOLD_F = 8'b0010_0010;
   localparam logic [7:0] C_EXC = 8'b0001_0010, C_STALL = 8'b0000_1000;
   localparam logic [7:0] C_RTI = 8'b0100_0110, C_HALTED = 8'b0010_0001;

   localparam logic [2:0] S_RUN = 3'd0, S_HDL = 3'd1, S_DRN = 3'd2, S_HLT = 3'd3;

   logic [26:0] exp_q[$];
   string       name_q[$];
   int          total = 0;
   int          bad = 0;

   function automatic logic [26:0] mk(input logic [7:0] c, input logic [2:0] s,
                                      input logic [15:0] e);
      return {c, s, e};
   endfunction

   task automatic step(input logic r, input logic [7:0] req, input logic [15:0] pc,
                       input logic [26:0] exp, input string name);
      @(posedge clk);
      #1;
      rst = r;
      {if_stall, dmem_stall, hazard_stall, br_taken, jr_taken, siic_dec, rti_dec, halt_dec} = req;
      ex_pc = pc;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   // Monitor: every cycle that carries an expectation is checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [26:0] e;
         logic [26:0] act;
         string       n;
         e   = exp_q.pop_front();
         n   = name_q.pop_front();
         act = {pc_sel, reg_jmp, hold, siic, pc_stall, epc_sel, flush, halted, state, epc};
         total++;
         if (act !== e) begin
           bad++;
           $display("FAIL %s: got ctl=%b st=%0d epc=%h, want ctl=%b st=%0d epc=%h",
                    n, act[26:19], act[18:16], act[15:0], e[26:19], e[18:16], e[15:0]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      {if_stall, dmem_stall, hazard_stall, br_taken, jr_taken, siic_dec, rti_dec, halt_dec} = '0;
      ex_pc = 16'h0000;

      step(1, R_HALT | R_BR, 16'h0, mk(C_INC, S_RUN, 16'h0), "in_reset");
      for (int i = 0; i < 4; i++) step(0, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0), "idle_inc");

      step(0, R_BR | R_JR | R_HALT, 16'h0, mk(C_BR, S_RUN, 16'h0), "br_wins");
      step(0, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0), "after_br");
      step(0, R_HAZ, 16'h0, mk(C_STALL, S_RUN, 16'h0), "haz_stall");
      step(0, R_JR, 16'h0, mk(C_JR, S_RUN, 16'h0), "jr");

      step(0, R_SIIC, 16'h0124, mk(C_EXC, S_RUN, 16'h0), "siic");
      step(0, R_NONE, 16'h0, mk(C_INC, S_HDL, 16'h0124), "epc_saved");
      step(0, R_HAZ, 16'h0, mk(C_STALL, S_HDL, 16'h0124), "hdl_stall");
      step(0, R_RTI, 16'h0, mk(C_RTI, S_HDL, 16'h0124), "rti");
      step(0, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0124), "after_rti");
      step(0, R_RTI, 16'h0, mk(C_INC, S_RUN, 16'h0124), "rti_in_run");

      step(0, R_HALT, 16'h0, mk(C_HOLD_F, S_RUN, 16'h0124), "halt_acc");
      step(0, R_NONE, 16'h0, mk(C_HOLD, S_DRN, 16'h0124), "drain1");
      step(0, R_BR, 16'h0, mk(C_BR, S_DRN, 16'h0124), "drain_redirect");
      step(0, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0124), "back_run");

      step(0, R_HALT, 16'h0, mk(C_HOLD_F, S_RUN, 16'h0124), "halt_acc2");
      for (int i = 0; i < 3; i++) step(0, R_NONE, 16'h0, mk(C_HOLD, S_DRN, 16'h0124), "drain");
      step(0, R_NONE, 16'h0, mk(C_HALTED, S_HLT, 16'h0124), "halted");
      step(0, R_BR, 16'h0, mk(C_HALTED, S_HLT, 16'h0124), "halted_sticky");
      step(1, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0), "rst_from_halted");

      for (int i = 0; i < 5; i++)
         step(0, R_DMEM | R_BR | R_HAZ, 16'h0, mk(C_HOLD, S_RUN, 16'h0), "dmem_hold");
      step(0, R_BR, 16'h0, mk(C_BR, S_RUN, 16'h0), "dmem_release");

      step(0, R_SIIC, 16'h0124, mk(C_EXC, S_RUN, 16'h0), "siic2");
      step(0, R_SIIC, 16'h0200, mk(C_HOLD_F, S_HDL, 16'h0124), "nested_siic");
      step(0, R_NONE, 16'h0, mk(C_HOLD, S_DRN, 16'h0124), "nested_drain");
      step(0, R_JR, 16'h0, mk(C_JR, S_DRN, 16'h0124), "drain_jr");
      step(0, R_NONE, 16'h0, mk(C_INC, S_HDL, 16'h0124), "back_handler");
      step(1, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0), "rst_in_handler");

      step(0, R_HALT, 16'h0, mk(C_HOLD_F, S_RUN, 16'h0), "halt_acc3");
      step(0, R_DMEM, 16'h0, mk(C_HOLD, S_DRN, 16'h0), "drain_frozen1");
      step(0, R_DMEM, 16'h0, mk(C_HOLD, S_DRN, 16'h0), "drain_frozen2");
      for (int i = 0; i < 3; i++) step(0, R_NONE, 16'h0, mk(C_HOLD, S_DRN, 16'h0), "drain_after_frz");
      step(0, R_NONE, 16'h0, mk(C_HALTED, S_HLT, 16'h0), "halted2");
      step(1, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0), "rst_from_halted2");

      step(0, R_SIIC, 16'h0124, mk(C_EXC, S_RUN, 16'h0), "siic3");
      step(0, R_HALT, 16'h0, mk(C_HOLD_F, S_HDL, 16'h0124), "halt_in_hdl");
      step(0, R_NONE, 16'h0, mk(C_HOLD, S_DRN, 16'h0124), "drain_mid");
      step(1, R_BR, 16'h0, mk(C_INC, S_RUN, 16'h0), "rst_mid_drain");
      step(0, R_NONE, 16'h0, mk(C_INC, S_RUN, 16'h0), "after_rst");

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_queue: got %0d left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
